// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// DIV_BYZERO_FLAG_EN adds the byzero_o response flag.
interface div_if #(
  parameter int DATA_W = 16
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
`ifdef DIV_BYZERO_FLAG_EN
  logic                  byzero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, byzero_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, byzero_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
`endif
endinterface

// File: rtl/div.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle.
// Result is {remainder, quotient}. DIV_BYZERO_FLAG_EN enables the byzero_o flag.
module div #(
  parameter int DATA_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     dvd_q;
  logic [DATA_W-1:0]     dvs_q;
  logic [DATA_W-1:0]     rem_q;
  logic                  qneg_q;
  logic                  rneg_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;
  logic                  byzero_q;

  logic [DATA_W:0]       upper_d;
  logic [DATA_W:0]       trial_d;
  logic [DATA_W-1:0]     rem_d;
  logic [DATA_W-1:0]     dvd_d;
  logic                  abort_d;

  // Magnitude of a possibly two's-complement operand; the most negative value
  // maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                           input logic is_signed);
    return (is_signed && x[DATA_W-1]) ? DATA_W'(-x) : DATA_W'(x);
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x,
                                              input logic negate);
    logic signed [DATA_W-1:0] xs;
    xs = x;
    return negate ? DATA_W'(-xs) : x;
  endfunction

  // One restoring step: shift {rem, dvd} left, trial-subtract the divisor from
  // the top DATA_W+1 bits, and shift the quotient bit into dvd's LSB.
  assign upper_d = {rem_q, dvd_q[DATA_W-1]};
  assign trial_d = upper_d - {1'b0, dvs_q};
  assign rem_d   = trial_d[DATA_W] ? upper_d[DATA_W-1:0] : trial_d[DATA_W-1:0];
  assign dvd_d   = {dvd_q[DATA_W-2:0], ~trial_d[DATA_W]};
  assign abort_d = bus.annul_i || !bus.start_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      byzero_q <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          byzero_q <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              dvd_q   <= mag(bus.opdata1_i, bus.signed_div_i);
              dvs_q   <= mag(bus.opdata2_i, bus.signed_div_i);
              rem_q   <= '0;
              cnt_q   <= '0;
              qneg_q  <= bus.signed_div_i &&
                         (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
              rneg_q  <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
              state_q <= ON;
            end
          end
        end
        BYZERO: begin
          result_q <= '0;
          if (abort_d) begin
            ready_q <= 1'b0;
            state_q <= FREE;
          end else begin
            ready_q  <= 1'b1;
            byzero_q <= 1'b1;
            state_q  <= END;
          end
        end
        ON: begin
          if (abort_d) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= FREE;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= {neg_if(rem_q, rneg_q), neg_if(dvd_q, qneg_q)};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          if (abort_d) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            byzero_q <= 1'b0;
            state_q  <= FREE;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
`ifdef DIV_BYZERO_FLAG_EN
  assign bus.byzero_o = byzero_q;
`else
  logic unused_byzero;
  assign unused_byzero = byzero_q;
`endif

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the restoring divider: directed cases from the test
// plan plus randomized requests against an integer-arithmetic reference model.
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  div_if #(.DATA_W(16)) bus();

  div #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    if (b == 16'h0) return 32'h0;
    if (s) begin
      int sa, sb, q, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[15:0], q[15:0]};
    end else begin
      int unsigned ua, ub, q, r;
      ua = a;
      ub = b;
      q  = ua / ub;
      r  = ua % ub;
      return {r[15:0], q[15:0]};
    end
  endfunction

  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int hold, input logic scramble, input string name);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    exp_res = model(a, b, s);
    exp_lat = (b == 16'h0) ? 1 : 17;
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 0 && scramble) begin
        bus.opdata1_i    = 16'($urandom);
        bus.opdata2_i    = 16'($urandom);
        bus.signed_div_i = 1'($urandom);
      end
      if (bus.ready_o === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.result_o !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h expected %h (a=%h b=%h s=%0d)",
               name, bus.result_o, exp_res, a, b, s);
    end
`ifdef DIV_BYZERO_FLAG_EN
    checks++;
    if (bus.byzero_o !== (b == 16'h0)) begin
      failures++;
      $display("FAIL %s byzero: got %b expected %b", name, bus.byzero_o, (b == 16'h0));
    end
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res) begin
        failures++;
        $display("FAIL %s hold: got ready=%b result=%h expected ready=1 result=%h",
                 name, bus.ready_o, bus.result_o, exp_res);
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 32'h0) begin
      failures++;
      $display("FAIL %s release: got ready=%b result=%h expected ready=0 result=0",
               name, bus.ready_o, bus.result_o);
    end
  endtask

  task automatic expect_idle(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s idle: ready_o high on %0d cycles, expected 0", name, seen);
    end
  endtask

  task automatic test_reset();
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 16'h0;
    bus.opdata2_i    = 16'h0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 32'h0) begin
      failures++;
      $display("FAIL reset: got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_idle(5, "post_reset");
  endtask

  task automatic test_unsigned();
    run_div(16'd100, 16'd7, 1'b0, 2, 1'b0, "u_100_7");
    run_div(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "u_ffff_1");
    run_div(16'h8000, 16'h0003, 1'b0, 0, 1'b1, "u_8000_3");
  endtask

  task automatic test_signed();
    run_div(16'hFFF9, 16'h0002, 1'b1, 0, 1'b0, "s_m7_2");
    run_div(16'h0007, 16'hFFFE, 1'b1, 0, 1'b0, "s_7_m2");
    run_div(16'h8000, 16'hFFFF, 1'b1, 0, 1'b0, "s_overflow");
    run_div(16'h8000, 16'h0003, 1'b1, 0, 1'b1, "s_min_3");
  endtask

  task automatic test_byzero();
    run_div(16'h1234, 16'h0000, 1'b0, 1, 1'b0, "byzero_u");
    run_div(16'h8000, 16'h0000, 1'b1, 0, 1'b0, "byzero_s");
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.opdata1_i    = 16'd1000;
    bus.opdata2_i    = 16'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (5) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    expect_idle(25, "abort");
    run_div(16'd50, 16'd5, 1'b0, 0, 1'b0, "after_abort");
    // annul together with start in FREE must never launch an operation
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    expect_idle(22, "annul_with_start");
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.opdata1_i    = 16'h7FFF;
    bus.opdata2_i    = 16'h0003;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_on: got ready=%b result=%h expected 0/0",
               bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expect_idle(20, "reset_mid_idle");
    // Reset while a result is being held must clear it without a clock edge.
    @(negedge clk);
    bus.opdata1_i = 16'd200;
    bus.opdata2_i = 16'd9;
    bus.start_i   = 1'b1;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 17 || bus.result_o !== model(16'd200, 16'd9, 1'b0)) begin
      failures++;
      $display("FAIL reset_end_setup: got lat=%0d result=%h expected lat=17 result=%h",
               lat, bus.result_o, model(16'd200, 16'd9, 1'b0));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_end: got ready=%b result=%h expected 0/0",
               bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expect_idle(3, "reset_end_idle");
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 5));
      run_div(a, b, 1'($urandom), $urandom_range(0, 2), 1'b1, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_div(16'd12345, 16'd123, 1'b0, 5, 1'b0, "b2b_first");
    run_div(16'hFF00, 16'h0011, 1'b1, 0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 16-bit signed/unsigned restoring divider serving the execute stage's divide request interface.
- The execute stage holds the request (start, operands, signedness) and stalls the pipeline until the ready strobe arrives.
- Returns {remainder, quotient}, which the execute stage writes to HI/LO (HI = remainder, LO = quotient).
- One quotient bit per cycle; operands are captured at start so later operand changes are ignored.

Parameters:
- DATA_W, 16, operand width; result width is 2*DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request. Held high by the requester until ready_o is seen, then dropped.
- annul_i  input  1  cancel the operation in progress (flush).
- result_o  output  2*DATA_W  {remainder[31:16], quotient[15:0]}; registered.
- ready_o  output  1  result valid; registered.

Behaviour:
- Reset (async, rst=1):
  - state=FREE, cnt=0.
  - result_o=0, ready_o=0.
  - All internal dividend/divisor/partial-remainder registers cleared immediately, including mid-operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0 at edge E0, sample opdata1_i, opdata2_i and signed_div_i.
  - If opdata2_i=0, go to BYZERO.
  - Otherwise capture |dividend| and |divisor|, clear the partial remainder, set cnt=0, go to ON.
  - Absolute value is taken only when signed_div_i=1 and the operand MSB=1; 0x8000 stays 0x8000 as an unsigned magnitude.
- BYZERO: on the next edge, result_o=0, ready_o=1, go to END.
- ON, while cnt<16, each edge performs one restoring step:
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor from the upper DATA_W+1 bits.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - cnt++.
- ON, when cnt=16, on the next edge apply sign correction:
  - Quotient is negated if signed_div_i=1 and the dividend and divisor signs differ.
  - Remainder is negated if signed_div_i=1 and the dividend is negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Register result_o, set ready_o=1, go to END.
- Latency:
  - Non-zero divisor: ready_o rises after edge E17, i.e. 17 cycles after the start-sampling edge.
  - Divide by zero: ready_o rises after edge E1.
- Abort from ON or BYZERO: if annul_i=1 or start_i=0 at an edge, go to FREE with ready_o=0 and result_o=0. No partial result is ever presented.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0, on that edge go to FREE with ready_o=0 and result_o=0.
  - annul_i in END also forces FREE.
- Back-to-back: a new request needs at least one cycle with start_i=0 after ready_o. start_i still high in END never restarts the divider.
- Overflow: signed 0x8000 / 0xFFFF gives quotient 0x8000 (wraps) and remainder 0x0000; no exception.
- Operand inputs are ignored outside FREE.
- annul_i and start_i together in FREE: annul_i wins; stay in FREE.

Optional Feature:
- Macro: DIV_BYZERO_FLAG_EN.
- Defined:
  - Adds output port byzero_o (1 bit), registered.
  - byzero_o is set with ready_o when the operation went through BYZERO.
  - It clears whenever ready_o clears; reset value 0.
- Not defined: the port is absent. A divide by zero is indistinguishable from a 0/x result except by its 2-cycle latency.

Test Plan:
- Unsigned: signed_div_i=0, 100/7, start held high -> ready_o rises 17 cycles after the sampling edge with result_o=0x0002000E. Drop start -> ready_o=0 and result_o=0 the next cycle.
- Signed: -7/2 (0xFFF9/0x0002) -> result_o=0xFFFFFFFD (rem -1, quot -3). Also 7/-2 -> 0x0001FFFD.
- Overflow/edge: signed 0x8000/0xFFFF -> result_o=0x00008000. Unsigned 0xFFFF/0x0001 -> result_o=0x0000FFFF.
- Divide by zero: 0x1234/0x0000 -> ready_o after 2 edges, result_o=0, byzero_o=1 when DIV_BYZERO_FLAG_EN is defined.
- Abort: annul_i pulsed on the 5th ON cycle -> ready_o stays 0 and state returns to FREE. A fresh 50/5 request then completes with 0x0000000A in 17 cycles.
- Reset mid-operation: assert rst asynchronously on the 10th ON cycle -> ready_o and result_o are 0 before the next clock edge. After release, an idle start_i produces no ready_o.
